// File: rtl/sram_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_ctrl_if
// CPU-side request bus of the SRAM controller.
//   AD    : CPU address                  (master -> slave)
//   DI    : write data                   (master -> slave)
//   rw    : 1 = read, 0 = write          (master -> slave)
//   cs    : access request               (master -> slave)
//   DO    : registered read data         (slave -> master)
//   ready : controller idle, cs accepted (slave -> master)
//   done  : one-cycle completion pulse   (slave -> master)
// -----------------------------------------------------------------------------
interface sram_ctrl_if #(
    parameter int CPU_AW = 16,
    parameter int DW     = 8
);
    logic [CPU_AW-1:0] AD;
    logic [DW-1:0]     DI;
    logic [DW-1:0]     DO;
    logic              rw;
    logic              cs;
    logic              ready;
    logic              done;

    modport master (output AD, DI, rw, cs, input DO, ready, done);
    modport slave  (input AD, DI, rw, cs, output DO, ready, done);
endinterface

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Sequences strobe cycles for an external asynchronous byte-wide SRAM.
// Reads hold OE_n low for RD_WAIT+1 cycles and capture data on the last one;
// writes use a setup / WE_n pulse (WR_WAIT cycles) / hold sequence. A bank
// register supplies the upper SRAM address bits.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : CPU request bus (sram_ctrl_if.slave)
//   bank_we    : load bank register with bank_di
//   bank_di    : new bank value
//   SRAM_AD    : registered SRAM address {bank, AD}
//   SRAM_DQ    : bidirectional SRAM data, driven only during write states
//   SRAM_WE_n  : write enable, active low, registered
//   SRAM_OE_n  : output enable, active low, registered
//   SRAM_CS2   : chip select, active high, registered
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int CPU_AW    = 16,
    parameter int BANK_BITS = 1,
    parameter int DW        = 8,
    parameter int RD_WAIT   = 1,
    parameter int WR_WAIT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    sram_ctrl_if.slave                  bus,
    input  logic                        bank_we,
    input  logic [BANK_BITS-1:0]        bank_di,
    output logic [CPU_AW+BANK_BITS-1:0] SRAM_AD,
    inout  wire  [DW-1:0]               SRAM_DQ,
    output logic                        SRAM_WE_n,
    output logic                        SRAM_OE_n,
    output logic                        SRAM_CS2
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW       = $clog2(MAX_WAIT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WPULSE,
        WHOLD,
        DONE
    } state_t;

    state_t               state, next_state;
    logic [CW-1:0]        cnt, cnt_next;
    logic                 accept;
    logic                 rd_capture;
    logic [BANK_BITS-1:0] bank;
    logic [DW-1:0]        wdata;
    logic [DW-1:0]        do_q;
    logic                 dq_oe;

    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == DONE);
    assign bus.DO    = do_q;
    assign SRAM_DQ   = dq_oe ? wdata : {DW{1'bz}};

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves it unassigned (which would infer a latch).
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        rd_capture = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cs) begin
                    accept = 1'b1;
                    if (bus.rw) begin
                        next_state = RD;
                        cnt_next   = CW'(RD_WAIT);
                    end else begin
                        next_state = WSETUP;
                    end
                end
            end
            RD: begin
                if (cnt == '0) begin
                    rd_capture = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WSETUP: begin
                next_state = WPULSE;
                cnt_next   = CW'(WR_WAIT - 1);
            end
            WPULSE: begin
                if (cnt == '0) begin
                    next_state = WHOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WHOLD:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are registered from next_state so that the pins already show the
    // new state's levels in the first cycle of that state.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register samples
        // pre-edge values (e.g. an accept coinciding with bank_we uses the old bank).
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bank      <= '0;
            SRAM_AD   <= '0;
            wdata     <= '0;
            do_q      <= '0;
            SRAM_CS2  <= 1'b0;
            SRAM_OE_n <= 1'b1;
            SRAM_WE_n <= 1'b1;
            dq_oe     <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (bank_we) begin
                bank <= bank_di;
            end
            if (accept) begin
                SRAM_AD <= {bank, bus.AD};
                wdata   <= bus.DI;
            end
            if (rd_capture) begin
                do_q <= SRAM_DQ;
            end
            SRAM_CS2  <= (next_state != IDLE) && (next_state != DONE);
            SRAM_OE_n <= (next_state != RD);
            SRAM_WE_n <= (next_state != WPULSE);
            dq_oe     <= (next_state == WSETUP) || (next_state == WPULSE) ||
                         (next_state == WHOLD);
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Directed bench for sram_ctrl (RD_WAIT=1, WR_WAIT=2) with a behavioural
// asynchronous SRAM on a pulled-up data bus (a released bus reads 8'hFF).
// Cycle n of an access is sampled 1 time unit after edge n-1 (edge 0 = accept).
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bank_we;
    logic [0:0]  bank_di;
    logic [16:0] sram_ad;
    tri1  [7:0]  sram_dq;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_cs2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:131071];

    sram_ctrl_if #(.CPU_AW(16), .DW(8)) bus ();

    sram_ctrl #(
        .CPU_AW(16), .BANK_BITS(1), .DW(8), .RD_WAIT(1), .WR_WAIT(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .bank_we   (bank_we),
        .bank_di   (bank_di),
        .SRAM_AD   (sram_ad),
        .SRAM_DQ   (sram_dq),
        .SRAM_WE_n (sram_we_n),
        .SRAM_OE_n (sram_oe_n),
        .SRAM_CS2  (sram_cs2)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: drives on read, stores on the rising edge of WE_n.
    assign sram_dq = (sram_cs2 && !sram_oe_n && sram_we_n) ? mem[sram_ad] : 8'bz;

    always @(posedge sram_we_n) begin
        if (sram_cs2 === 1'b1) mem[sram_ad] = sram_dq;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in an idle cycle; returns in cycle 1 with cs dropped.
    task automatic start(input logic r, input logic [15:0] a, input logic [7:0] d);
        bus.cs = 1'b1;
        bus.rw = r;
        bus.AD = a;
        bus.DI = d;
        tick();
        bus.cs = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        checks++; if (bus.DO !== 8'h00) begin failures++; $display("FAIL rst_do got=%h exp=00", bus.DO); end
        checks++; if (sram_ad !== 17'h00000) begin failures++; $display("FAIL rst_ad got=%h exp=00000", sram_ad); end
        checks++; if (sram_cs2 !== 1'b0) begin failures++; $display("FAIL rst_cs2 got=%b exp=0", sram_cs2); end
        checks++; if (sram_oe_n !== 1'b1) begin failures++; $display("FAIL rst_oe_n got=%b exp=1", sram_oe_n); end
        checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL rst_we_n got=%b exp=1", sram_we_n); end
        checks++; if (sram_dq !== 8'hFF) begin failures++; $display("FAIL rst_dq_released got=%h exp=FF", sram_dq); end
    endtask

    task automatic test_read();
        start(1'b1, 16'h1234, 8'h00);
        checks++; if (sram_oe_n !== 1'b0) begin failures++; $display("FAIL rd_oe_c1 got=%b exp=0", sram_oe_n); end
        checks++; if (sram_cs2 !== 1'b1) begin failures++; $display("FAIL rd_cs2_c1 got=%b exp=1", sram_cs2); end
        checks++; if (sram_ad !== 17'h01234) begin failures++; $display("FAIL rd_ad_c1 got=%h exp=01234", sram_ad); end
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL rd_ready_c1 got=%b exp=0", bus.ready); end
        tick();
        checks++; if (sram_oe_n !== 1'b0) begin failures++; $display("FAIL rd_oe_c2 got=%b exp=0", sram_oe_n); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rd_done_c2 got=%b exp=0", bus.done); end
        tick();
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL rd_done_c3 got=%b exp=1", bus.done); end
        checks++; if (bus.DO !== 8'hA5) begin failures++; $display("FAIL rd_do_c3 got=%h exp=A5", bus.DO); end
        checks++; if (sram_oe_n !== 1'b1) begin failures++; $display("FAIL rd_oe_c3 got=%b exp=1", sram_oe_n); end
        checks++; if (sram_cs2 !== 1'b0) begin failures++; $display("FAIL rd_cs2_c3 got=%b exp=0", sram_cs2); end
        tick();
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL rd_ready_c4 got=%b exp=1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rd_done_c4 got=%b exp=0", bus.done); end
        checks++; if (sram_ad !== 17'h01234) begin failures++; $display("FAIL rd_ad_hold_c4 got=%h exp=01234", sram_ad); end
    endtask

    task automatic test_write();
        logic       exp_we;
        logic [7:0] exp_dq;
        start(1'b0, 16'hFFFF, 8'h3C);
        for (int c = 1; c <= 5; c++) begin
            exp_we = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            exp_dq = (c <= 4) ? 8'h3C : 8'hFF;
            checks++; if (sram_we_n !== exp_we) begin failures++; $display("FAIL wr_we_n_c%0d got=%b exp=%b", c, sram_we_n, exp_we); end
            checks++; if (sram_dq !== exp_dq) begin failures++; $display("FAIL wr_dq_c%0d got=%h exp=%h", c, sram_dq, exp_dq); end
            checks++; if (sram_oe_n !== 1'b1) begin failures++; $display("FAIL wr_oe_n_c%0d got=%b exp=1", c, sram_oe_n); end
            checks++; if (bus.done !== (c == 5)) begin failures++; $display("FAIL wr_done_c%0d got=%b exp=%b", c, bus.done, (c == 5)); end
            if (c < 5) tick();
        end
        checks++; if (sram_ad !== 17'h0FFFF) begin failures++; $display("FAIL wr_ad got=%h exp=0FFFF", sram_ad); end
        checks++; if (mem[17'h0FFFF] !== 8'h3C) begin failures++; $display("FAIL wr_mem got=%h exp=3C", mem[17'h0FFFF]); end
        checks++; if (bus.DO !== 8'hA5) begin failures++; $display("FAIL wr_do_kept got=%h exp=A5", bus.DO); end
        tick();
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL wr_ready_c6 got=%b exp=1", bus.ready); end
    endtask

    task automatic test_bank();
        bank_we = 1'b1;
        bank_di = 1'b1;
        tick();
        bank_we = 1'b0;
        start(1'b1, 16'h0010, 8'h00);
        checks++; if (sram_ad !== 17'h10010) begin failures++; $display("FAIL bank_ad got=%h exp=10010", sram_ad); end
        tick();
        tick();
        checks++; if (bus.DO !== 8'h5A) begin failures++; $display("FAIL bank_do got=%h exp=5A", bus.DO); end
        tick();
        // Bank load on the accept edge: this access keeps the old bank (1).
        bank_we = 1'b1;
        bank_di = 1'b0;
        start(1'b1, 16'h0010, 8'h00);
        bank_we = 1'b0;
        checks++; if (sram_ad !== 17'h10010) begin failures++; $display("FAIL bank_same_edge_ad got=%h exp=10010", sram_ad); end
        tick();
        tick();
        tick();
        start(1'b1, 16'h0010, 8'h00);
        checks++; if (sram_ad !== 17'h00010) begin failures++; $display("FAIL bank_new_ad got=%h exp=00010", sram_ad); end
        tick();
        tick();
        checks++; if (bus.DO !== 8'hC3) begin failures++; $display("FAIL bank_new_do got=%h exp=C3", bus.DO); end
        tick();
    endtask

    // cs held high; read (4-cycle period) and write (6-cycle period) alternate.
    task automatic test_back_to_back();
        int         next_acc;
        int         acc_n;
        logic       nxt_rw;
        logic       last_rw;
        logic [7:0] wd;
        bus.cs   = 1'b1;
        bus.rw   = 1'b1;
        bus.AD   = 16'h1234;
        bus.DI   = 8'h00;
        last_rw  = 1'b1;
        nxt_rw   = 1'b0;
        next_acc = 4;
        acc_n    = 1;
        wd       = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++; if (bus.ready !== (c == next_acc)) begin failures++; $display("FAIL b2b_ready_c%0d got=%b exp=%b", c, bus.ready, (c == next_acc)); end
            checks++; if (bus.done !== (c == next_acc - 1)) begin failures++; $display("FAIL b2b_done_c%0d got=%b exp=%b", c, bus.done, (c == next_acc - 1)); end
            checks++; if ((sram_oe_n | sram_we_n) !== 1'b1) begin failures++; $display("FAIL b2b_overlap_c%0d oe_n=%b we_n=%b exp_not_both_low", c, sram_oe_n, sram_we_n); end
            if (c == next_acc - 1 && last_rw) begin
                checks++; if (bus.DO !== 8'hA5) begin failures++; $display("FAIL b2b_do_c%0d got=%h exp=A5", c, bus.DO); end
            end
            if (c == next_acc) begin
                if (acc_n == 6) begin
                    bus.cs = 1'b0;
                    break;
                end
                bus.rw = nxt_rw;
                bus.AD = nxt_rw ? 16'h1234 : 16'h0040;
                if (!nxt_rw) wd = wd + 8'h11;
                bus.DI   = wd;
                last_rw  = nxt_rw;
                next_acc = next_acc + (nxt_rw ? 4 : 6);
                nxt_rw   = !nxt_rw;
                acc_n++;
            end
        end
        tick();
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL b2b_end_ready got=%b exp=1", bus.ready); end
        checks++; if (mem[17'h00040] !== 8'h33) begin failures++; $display("FAIL b2b_mem got=%h exp=33", mem[17'h00040]); end
    endtask

    task automatic test_busy_ignore();
        start(1'b1, 16'h1234, 8'h00);
        bus.AD = 16'hFFFF;
        bus.rw = 1'b0;
        checks++; if (sram_ad !== 17'h01234) begin failures++; $display("FAIL busy_ad_c1 got=%h exp=01234", sram_ad); end
        checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL busy_we_n_c1 got=%b exp=1", sram_we_n); end
        tick();
        bus.cs = 1'b1;
        checks++; if (sram_oe_n !== 1'b0) begin failures++; $display("FAIL busy_oe_c2 got=%b exp=0", sram_oe_n); end
        checks++; if (sram_ad !== 17'h01234) begin failures++; $display("FAIL busy_ad_c2 got=%h exp=01234", sram_ad); end
        tick();
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL busy_done_c3 got=%b exp=1", bus.done); end
        checks++; if (bus.DO !== 8'hA5) begin failures++; $display("FAIL busy_do_c3 got=%h exp=A5", bus.DO); end
        tick();
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL busy_ready_c4 got=%b exp=1", bus.ready); end
        checks++; if (sram_cs2 !== 1'b0) begin failures++; $display("FAIL busy_cs2_c4 got=%b exp=0", sram_cs2); end
        bus.cs = 1'b0;
        tick();
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL busy_ready_c5 got=%b exp=1", bus.ready); end
        checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL busy_we_n_c5 got=%b exp=1", sram_we_n); end
    endtask

    task automatic test_reset_mid_write();
        bank_we = 1'b1;
        bank_di = 1'b1;
        tick();
        bank_we = 1'b0;
        start(1'b0, 16'h0020, 8'h77);
        tick();
        checks++; if (sram_we_n !== 1'b0) begin failures++; $display("FAIL rmw_we_n_pulse got=%b exp=0", sram_we_n); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL rmw_we_n got=%b exp=1", sram_we_n); end
        checks++; if (sram_cs2 !== 1'b0) begin failures++; $display("FAIL rmw_cs2 got=%b exp=0", sram_cs2); end
        checks++; if (sram_dq !== 8'hFF) begin failures++; $display("FAIL rmw_dq_released got=%h exp=FF", sram_dq); end
        checks++; if (bus.DO !== 8'h00) begin failures++; $display("FAIL rmw_do got=%h exp=00", bus.DO); end
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL rmw_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rmw_done got=%b exp=0", bus.done); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rmw_no_done_%0d got=%b exp=0", c, bus.done); end
            checks++; if (sram_cs2 !== 1'b0) begin failures++; $display("FAIL rmw_no_strobe_%0d got=%b exp=0", c, sram_cs2); end
        end
        start(1'b1, 16'h0010, 8'h00);
        checks++; if (sram_ad !== 17'h00010) begin failures++; $display("FAIL rmw_bank_cleared got=%h exp=00010", sram_ad); end
        tick();
        tick();
        checks++; if (bus.DO !== 8'hC3) begin failures++; $display("FAIL rmw_read_do got=%h exp=C3", bus.DO); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem[17'h01234] = 8'hA5;
        mem[17'h10010] = 8'h5A;
        mem[17'h00010] = 8'hC3;
        rst     = 1'b1;
        bank_we = 1'b0;
        bank_di = 1'b0;
        bus.cs  = 1'b0;
        bus.rw  = 1'b1;
        bus.AD  = 16'h0000;
        bus.DI  = 8'h00;

        test_reset();
        test_read();
        test_write();
        test_bank();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_write();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Clocked controller for an external asynchronous byte-wide SRAM.
- Turns CPU read/write requests into properly sequenced SRAM strobe cycles.
- Adds programmable wait states, a bank register that drives the upper SRAM address bits, and a valid/ready handshake.
- Sits between the CPU bus decoder and the SRAM pins; it is the next-generation SRAM interface for larger parts and slower memories.

Parameters:
- CPU_AW, 16: CPU address width.
- BANK_BITS, 1: bank register width. Upper SRAM address bits; SRAM address width = CPU_AW+BANK_BITS.
- DW, 8: data width.
- RD_WAIT, 1: extra read access cycles, >=0.
- WR_WAIT, 1: WE_n low cycles, >=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- AD  in  CPU_AW  CPU address.
- DI  in  DW  CPU write data.
- DO  out  DW  registered read data.
- rw  in  1  1=read, 0=write.
- cs  in  1  access request.
- ready  out  1  controller idle, request accepted this cycle if cs=1.
- done  out  1  one-cycle pulse, access complete.
- bank_we  in  1  load bank register.
- bank_di  in  BANK_BITS  new bank value.
- SRAM_AD  out  CPU_AW+BANK_BITS  SRAM address, registered.
- SRAM_DQ  inout  DW  SRAM data bus.
- SRAM_WE_n  out  1  write enable, active low, registered.
- SRAM_OE_n  out  1  output enable, active low, registered.
- SRAM_CS2  out  1  chip select, active high, registered.

Behaviour:
- Reset (rst=1 at an edge), effective the next cycle from any state:
  - state=IDLE, DO=0, bank=0, SRAM_AD=0, SRAM_CS2=0, SRAM_OE_n=1, SRAM_WE_n=1, SRAM_DQ=Z, done=0.
  - An access in flight is abandoned, with no further strobes.
- ready=1 only in IDLE; it is combinational from state. Accept = cs&ready at an edge.
- On accept, latch {bank,AD}, DI and rw. cs is ignored while ready=0. The requester may hold cs high; a new access is accepted in the first IDLE cycle.
- bank_we loads bank at any time. It affects only accesses accepted after the load edge. If bank_we coincides with accept, the old bank is used.
- States: IDLE, RD, WSETUP, WPULSE, WHOLD, DONE. Cycle 0 = accept edge.
- Read path:
  - IDLE->RD: SRAM_CS2=1, SRAM_OE_n=0, SRAM_AD valid, for RD_WAIT+1 cycles; a counter counts down.
  - On the final RD edge, DO<=SRAM_DQ.
  - Then DONE: strobes inactive, done=1.
  - done appears RD_WAIT+2 cycles after accept.
- Write path:
  - WSETUP, 1 cycle: CS2=1, WE_n=1, DQ driven with latched DI.
  - WPULSE, WR_WAIT cycles: WE_n=0.
  - WHOLD, 1 cycle: WE_n=1, data and address still driven.
  - Then DONE. done appears WR_WAIT+3 cycles after accept.
- SRAM_DQ is driven only in WSETUP/WPULSE/WHOLD; it is Z otherwise. OE_n and WE_n are never low simultaneously.
- DONE->IDLE unconditionally. DONE lasts exactly 1 cycle, so the minimum gap between accepts is access length +1.
- DO holds its value until the next read completes; writes do not alter DO.
- SRAM_AD holds the last address in IDLE/DONE. Only CS2 and the strobes return inactive.
- Counter width is $clog2(max(RD_WAIT,WR_WAIT)+1)+1. RD_WAIT=0 gives a single RD cycle.

Test Plan:
- Read, RD_WAIT=1, bank=0: cs=1, rw=1, AD=16'h1234, SRAM model returns 8'hA5.
  - -> OE_n low for 2 cycles, SRAM_AD=17'h01234.
  - -> done at cycle 3, DO=8'hA5, ready back at cycle 4.
- Write, WR_WAIT=2: cs=1, rw=0, AD=16'hFFFF, DI=8'h3C.
  - -> DQ=8'h3C cycles 1–4, WE_n low cycles 2–3 only, done at cycle 5.
  - -> the model holds 8'h3C at FFFF, and DQ=Z at cycle 5.
- Bank: bank_we=1, bank_di=1, then a read of AD=16'h0010.
  - -> SRAM_AD=17'h10010.
  - Also bank_we in the same cycle as an accept -> that access still uses the old bank.
- Back-to-back: cs held high with alternating rw.
  - -> accepts only when ready=1.
  - -> no OE_n/WE_n overlap, and done pulses exactly once per access.
- Reset mid-write: assert rst during WPULSE.
  - -> next cycle WE_n=1, CS2=0, DQ=Z, DO=0, bank=0, ready=1, and no done pulse.
- Busy ignore: during a read, toggle cs and change AD/rw.
  - -> the access completes with the originally latched address, and no extra access starts until IDLE.
